// File: rtl/dfx_seq_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dfx_seq_scheduler
// Description : Slot-table sequencer. On start it walks rows 0..end_cnt; for
//               every pending row it asks the DFX controller to load the
//               reconfigurable module, issues one DMA job with the row's
//               src/dst fields, and writes status plus a cycle-count profile
//               back into the row.
// Ports       : clk/reset (async active-low)  | ctrl_start/ctrl_abort pulses
//               end_cnt                       | slot_* row read / writeback
//               dfx_req/dfx_rm_id/dfx_ack/dfx_err  DFX controller handshake
//               dma_req/dma_* job/dma_ack/dma_done/dma_err  DMA handshake
//               busy/done/error/cur_index     status to register bank
// Revision    : 1.0 - initial release
// ============================================================================
module dfx_seq_scheduler #(
   parameter int IDX_W  = 3,
   parameter int ADDR_W = 32,
   parameter int SIZE_W = 26,
   parameter int STAT_W = 2,
   parameter int PROF_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ctrl_start,
   input  logic              ctrl_abort,
   input  logic [IDX_W-1:0]  end_cnt,
   output logic [IDX_W-1:0]  slot_rd_index,
   input  logic [ADDR_W-1:0] slot_src_addr,
   input  logic [SIZE_W-1:0] slot_src_size,
   input  logic [ADDR_W-1:0] slot_des_addr,
   input  logic [SIZE_W-1:0] slot_des_size,
   input  logic [STAT_W-1:0] slot_status,
   output logic [IDX_W-1:0]  slot_wr_index,
   output logic [STAT_W-1:0] slot_wr_status,
   output logic              slot_set_status,
   output logic [PROF_W-1:0] slot_wr_profile,
   output logic              slot_set_profile,
   output logic              dfx_req,
   output logic [IDX_W-1:0]  dfx_rm_id,
   input  logic              dfx_ack,
   input  logic              dfx_err,
   output logic              dma_req,
   output logic [ADDR_W-1:0] dma_src_addr,
   output logic [ADDR_W-1:0] dma_des_addr,
   output logic [SIZE_W-1:0] dma_src_size,
   output logic [SIZE_W-1:0] dma_des_size,
   input  logic              dma_ack,
   input  logic              dma_done,
   input  logic              dma_err,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [IDX_W-1:0]  cur_index
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DFX_REQ  = 4'd2,
      S_DFX_WAIT = 4'd3,
      S_DMA_REQ  = 4'd4,
      S_DMA_WAIT = 4'd5,
      S_WRBACK   = 4'd6,
      S_NEXT     = 4'd7,
      S_DONE     = 4'd8
   } state_t;

   localparam logic [STAT_W-1:0] c_ST_PEND = STAT_W'(2'b01);
   localparam logic [STAT_W-1:0] c_ST_DONE = STAT_W'(2'b10);
   localparam logic [STAT_W-1:0] c_ST_ERR  = STAT_W'(2'b11);

   state_t            r_state;
   logic [IDX_W-1:0]  r_index;
   logic [IDX_W-1:0]  r_end;
   logic              r_abort_pend;
   logic [PROF_W-1:0] r_cnt;
   logic [STAT_W-1:0] r_wr_status;
   logic [PROF_W-1:0] r_wr_profile;
   logic              r_set;
   logic              r_dfx_req;
   logic              r_dma_req;
   logic [ADDR_W-1:0] r_src_addr;
   logic [ADDR_W-1:0] r_des_addr;
   logic [SIZE_W-1:0] r_src_size;
   logic [SIZE_W-1:0] r_des_size;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   // Profile counter saturates instead of wrapping.
   logic [PROF_W-1:0] w_cnt_inc;
   assign w_cnt_inc = (r_cnt == {PROF_W{1'b1}}) ? r_cnt : r_cnt + PROF_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_index      <= '0;
         r_end        <= '0;
         r_abort_pend <= 1'b0;
         r_cnt        <= '0;
         r_wr_status  <= '0;
         r_wr_profile <= '0;
         r_set        <= 1'b0;
         r_dfx_req    <= 1'b0;
         r_dma_req    <= 1'b0;
         r_src_addr   <= '0;
         r_des_addr   <= '0;
         r_src_size   <= '0;
         r_des_size   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         // Writeback strobes are single-cycle; set only on entry to WRBACK.
         r_set <= 1'b0;

         // Abort is remembered while a run is active and acted on at NEXT.
         if (ctrl_abort && (r_state != S_IDLE))
            r_abort_pend <= 1'b1;

         case (r_state)
            S_IDLE: begin
               // Start wins over a simultaneous abort (pending cleared below).
               if (ctrl_start) begin
                  r_state      <= S_FETCH;
                  r_index      <= '0;
                  r_end        <= end_cnt;
                  r_abort_pend <= 1'b0;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end

            S_FETCH: begin
               if (slot_status == c_ST_PEND) begin
                  r_src_addr <= slot_src_addr;
                  r_src_size <= slot_src_size;
                  r_des_addr <= slot_des_addr;
                  r_des_size <= slot_des_size;
                  r_cnt      <= '0;
                  r_dfx_req  <= 1'b1;
                  r_state    <= S_DFX_REQ;
               end else begin
                  r_state <= S_NEXT;
               end
            end

            S_DFX_REQ, S_DFX_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (dfx_ack) begin
                  r_dfx_req <= 1'b0;
                  if (dfx_err) begin
                     r_wr_status  <= c_ST_ERR;
                     r_wr_profile <= w_cnt_inc;
                     r_set        <= 1'b1;
                     r_state      <= S_WRBACK;
                  end else begin
                     r_dma_req <= 1'b1;
                     r_state   <= S_DMA_REQ;
                  end
               end else begin
                  r_state <= S_DFX_WAIT;
               end
            end

            S_DMA_REQ: begin
               // dma_done is not looked at here: completion before acceptance is ignored.
               r_cnt <= w_cnt_inc;
               if (dma_ack) begin
                  r_dma_req <= 1'b0;
                  r_state   <= S_DMA_WAIT;
               end
            end

            S_DMA_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (dma_done) begin
                  r_wr_status  <= dma_err ? c_ST_ERR : c_ST_DONE;
                  r_wr_profile <= w_cnt_inc;
                  r_set        <= 1'b1;
                  r_state      <= S_WRBACK;
               end
            end

            S_WRBACK: begin
               if (r_wr_status == c_ST_ERR)
                  r_error <= 1'b1;
               r_state <= S_NEXT;
            end

            S_NEXT: begin
               if ((r_index == r_end) || r_abort_pend || ctrl_abort) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_index <= r_index + IDX_W'(1);
                  r_state <= S_FETCH;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign slot_rd_index    = r_index;
   assign slot_wr_index    = r_index;
   assign slot_wr_status   = r_wr_status;
   assign slot_set_status  = r_set;
   assign slot_wr_profile  = r_wr_profile;
   assign slot_set_profile = r_set;
   assign dfx_req          = r_dfx_req;
   assign dfx_rm_id        = r_index;
   assign dma_req          = r_dma_req;
   assign dma_src_addr     = r_src_addr;
   assign dma_des_addr     = r_des_addr;
   assign dma_src_size     = r_src_size;
   assign dma_des_size     = r_des_size;
   assign busy             = r_busy;
   assign done             = r_done;
   assign error            = r_error;
   assign cur_index        = r_index;

endmodule
`default_nettype wire
